// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier digit per clock.
// Computes a signed WIDTH x WIDTH -> 2*WIDTH product in WIDTH/2 RUN cycles.
module booth_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 enc_neg,
    output logic                 enc_zero,
    output logic                 enc_one,
    output logic                 enc_two
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH / 2) + 1;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH / 2 - 1);

    // Radix-4 Booth digit decode, packed as {neg, zero, one, two}.
    function automatic logic [3:0] booth_enc(input logic [2:0] trip);
        logic [3:0] e;
        case (trip)
            3'b000, 3'b111: e = 4'b0100;
            3'b001, 3'b010: e = 4'b0010;
            3'b011:         e = 4'b0001;
            3'b100:         e = 4'b1001;
            3'b101, 3'b110: e = 4'b1010;
            default:        e = 4'b0100;
        endcase
        return e;
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH:0]   mplier_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    step_r;
    logic [PW-1:0]    product_r;
    logic [3:0]       enc_r;

    logic [3:0]       cur_enc_s;
    logic [PW-1:0]    mcand_ext_s;
    logic [PW-1:0]    mag_s;
    logic [PW-1:0]    signed_pp_s;
    logic [PW-1:0]    pp_s;
    logic [PW-1:0]    acc_sum_s;
    logic [WIDTH:0]   mplier_shift_s;

    assign cur_enc_s      = booth_enc(mplier_r[2:0]);
    assign mcand_ext_s    = {{WIDTH{mcand_r[WIDTH-1]}}, mcand_r};
    assign mplier_shift_s = {{2{mplier_r[WIDTH]}}, mplier_r[WIDTH:2]};

    // Partial product of the current digit, weighted by 4^step.
    always_comb begin
        mag_s       = {PW{1'b0}};
        signed_pp_s = {PW{1'b0}};
        if (cur_enc_s[0]) begin
            mag_s = mcand_ext_s << 1;
        end else if (cur_enc_s[1]) begin
            mag_s = mcand_ext_s;
        end else begin
            mag_s = {PW{1'b0}};
        end
        if (cur_enc_s[3]) begin
            signed_pp_s = ~mag_s + PW'(1);
        end else begin
            signed_pp_s = mag_s;
        end
    end

    assign pp_s      = signed_pp_s << {step_r, 1'b0};
    assign acc_sum_s = acc_r + pp_s;

    // Control FSM and datapath registers; the encoder port is loaded one step ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {(WIDTH+1){1'b0}};
            acc_r     <= {PW{1'b0}};
            step_r    <= {CW{1'b0}};
            product_r <= {PW{1'b0}};
            enc_r     <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r  <= a;
                        mplier_r <= {b, 1'b0};
                        acc_r    <= {PW{1'b0}};
                        step_r   <= {CW{1'b0}};
                        enc_r    <= booth_enc({b[1:0], 1'b0});
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    acc_r    <= acc_sum_s;
                    mplier_r <= mplier_shift_s;
                    step_r   <= step_r + CW'(1);
                    if (step_r == LAST_STEP) begin
                        product_r <= acc_sum_s;
                        enc_r     <= 4'b0000;
                        state_r   <= DONE;
                    end else begin
                        enc_r     <= booth_enc(mplier_shift_s[2:0]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    enc_r   <= 4'b0000;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign product   = product_r;
    assign enc_neg   = enc_r[3];
    assign enc_zero  = enc_r[2];
    assign enc_one   = enc_r[1];
    assign enc_two   = enc_r[0];

endmodule

// File: doc/booth_seq_mul.md
BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be even and at least 4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair on a/b is offered.
REQ-005 in_ready  output  1  block accepts operands (high only in IDLE).
REQ-006 a  input  WIDTH  multiplicand, two's complement.
REQ-007 b  input  WIDTH  multiplier, two's complement; this is the operand being Booth-recoded.
REQ-008 out_valid  output  1  product holds a completed result.
REQ-009 out_ready  input  1  consumer accepts product.
REQ-010 product  output  2*WIDTH  signed product a*b.
REQ-011 enc_neg, enc_zero, enc_one, enc_two  output  1 each  radix-4 Booth control of the current step (observation port).

Function
REQ-012 The FSM SHALL have exactly the states IDLE, RUN and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-013 IDLE: on a rising edge with in_valid=1, the block SHALL latch a, latch {b,1'b0} (WIDTH+1 bits), clear the accumulator and step counter, and enter RUN; a and b SHALL be ignored at all other times.
REQ-014 RUN step i (i = 0..WIDTH/2-1) SHALL recode the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0, as follows: 000/111 -> zero; 001/010 -> +1x; 011 -> +2x; 100 -> -2x; 101/110 -> -1x.
REQ-015 Encoder outputs SHALL be one-hot among zero/one/two; enc_neg=1 only for triplets 100, 101 and 110; outside RUN, all four SHALL be 0.
REQ-016 Partial product: sign-extend a (or a<<1 for 2x) to 2*WIDTH bits; for neg, form the two's complement (invert, add 1); shift left by 2i; add into a 2*WIDTH-bit accumulator modulo 2^(2*WIDTH).
REQ-017 Each RUN cycle SHALL arithmetic-shift the latched multiplier right by 2 and increment the step counter; the step counter SHALL NOT wrap within an operation.
REQ-018 After step WIDTH/2-1 the block SHALL copy the accumulator to product and enter DONE.
REQ-019 Latency: if the operand handshake occurs at edge T, step i's encoder outputs SHALL be visible between edges T+i and T+i+1, and out_valid SHALL rise after edge T+WIDTH/2 (16 edges for WIDTH=32).
REQ-020 DONE: product and out_valid SHALL hold while out_ready=0; on an edge with out_ready=1 the block SHALL return to IDLE, so in_ready rises the cycle after the result handshake (no same-cycle accept).
REQ-021 product SHALL hold the last completed result until the next completion.
REQ-022 The full signed range SHALL be exact, including a = b = -2^(WIDTH-1).
REQ-023 in_valid during RUN or DONE SHALL have no effect; out_ready outside DONE SHALL have no effect.

Reset
REQ-024 While rst_n=0, independent of clk: state=IDLE, in_ready=1, out_valid=0, product=0, enc_*=0, accumulator, counter and operand registers=0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no partial result visible; the first operation after release SHALL be correct.

Verification
REQ-026 a=3, b=5 -> step0 enc_one=1 enc_neg=0, step1 enc_one=1, steps2-15 enc_zero=1; out_valid after edge T+16; product=15.
REQ-027 a=-7, b=6 -> step0 -2x (enc_two=1, enc_neg=1), step1 +2x; product=0xFFFF_FFFF_FFFF_FFD6.
REQ-028 a=b=0x8000_0000 -> product=0x4000_0000_0000_0000; a=0x7FFF_FFFF, b=0xFFFF_FFFF -> product=0xFFFF_FFFF_8000_0001.
REQ-029 out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> product stable, in_ready=0, new operands ignored; out_ready=1 -> IDLE, and the next accept yields the new product.
REQ-030 rst_n pulsed low during RUN step 8 -> immediately out_valid=0, product=0, in_ready=1, enc_*=0; then a=-1, b=-1 -> product=1.
REQ-031 Random signed pairs (at least 10k, including 0, +/-1, MIN, MAX) with random out_ready stalls -> every product equals the 64-bit reference multiply.
